msrv32_decode_buffer: RTL and testbench

- Parametrised instruction decode stage with a DEPTH-entry instruction/PC queue between fetch and decode.
- Uses a valid/ready handshake on both sides.
- Presents RV32I field extraction for the queue head, plus an illegal-opcode flag.
- Flush empties the queue and forces a NOP (ADDI x0,x0,0) onto the decoded outputs.

---
 rtl/msrv32_decode_buffer.sv | 130 +++++++++++++
 tb/tb_msrv32_decode_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_decode_buffer.sv
// Decode stage for msrv32: a DEPTH-entry {instr, pc} queue between fetch and
// decode, with RV32I field extraction and an illegal-opcode flag on the head.
module msrv32_decode_buffer #(
    parameter int               WIDTH      = 32,
    parameter int               ADDR_WIDTH = 5,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                         ms_riscv32_mp_clk_in,
    input  logic                         ms_riscv32_mp_rst_in,
    input  logic                         flush_in,
    input  logic [WIDTH-1:0]             instr_in,
    input  logic [WIDTH-1:0]             pc_in,
    input  logic                         instr_valid_in,
    output logic                         instr_ready_out,
    input  logic                         dec_ready_in,
    output logic                         dec_valid_out,
    output logic [6:0]                   opcode_out,
    output logic [2:0]                   funct3_out,
    output logic [6:0]                   funct7_out,
    output logic [ADDR_WIDTH-1:0]        rs1_addr_out,
    output logic [ADDR_WIDTH-1:0]        rs2_addr_out,
    output logic [ADDR_WIDTH-1:0]        rd_addr_out,
    output logic [11:0]                  csr_addr_out,
    output logic [24:0]                  instr_out,
    output logic [WIDTH-1:0]             pc_out,
    output logic                         illegal_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [WIDTH-1:0] pc_mem_q    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             push;
    logic             pop;
    logic             opcode_legal;
    logic [WIDTH-1:0] sel_instr;

    // Handshake: a full queue still accepts when the head leaves this cycle.
    always_comb begin
        dec_valid_out   = (count_q != '0) && !flush_in;
        pop             = dec_valid_out && dec_ready_in;
        instr_ready_out = (count_q < CNT_MAX) || pop;
        push            = instr_valid_in && instr_ready_out && !flush_in;
    end

    // NOTE: next-state logic lives in always_comb with a default for every
    // output first, so no path can leave a signal unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_in) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the entry storage is deliberately not reset; count_q alone says
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= instr_in;
            pc_mem_q[wr_ptr_q]    <= pc_in;
        end
    end

    always_comb begin
        sel_instr = dec_valid_out ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
        pc_out    = dec_valid_out ? pc_mem_q[rd_ptr_q] : '0;
    end

    assign opcode_out   = sel_instr[6:0];
    assign funct3_out   = sel_instr[14:12];
    assign funct7_out   = sel_instr[31:25];
    assign rs1_addr_out = sel_instr[15 +: ADDR_WIDTH];
    assign rs2_addr_out = sel_instr[20 +: ADDR_WIDTH];
    assign rd_addr_out  = sel_instr[7 +: ADDR_WIDTH];
    assign csr_addr_out = sel_instr[31:20];
    assign instr_out    = sel_instr[31:7];
    assign count_out    = count_q;

    // Every RV32I base opcode ends in 2'b11, so this list also rejects
    // compressed encodings.
    always_comb begin
        opcode_legal = 1'b0;
        case (sel_instr[6:0])
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
            7'b0110011, 7'b0001111, 7'b1110011: opcode_legal = 1'b1;
            default:                            opcode_legal = 1'b0;
        endcase
    end

    assign illegal_out = dec_valid_out && !opcode_legal;

endmodule

// File: tb/tb_msrv32_decode_buffer.sv
// Scoreboard bench for msrv32_decode_buffer: a queue model predicts handshake,
// occupancy and the decoded head, checked every cycle before the rising edge.
module tb_msrv32_decode_buffer;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst_n;
    logic        flush_in;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        instr_valid_in;
    logic        instr_ready_out;
    logic        dec_ready_in;
    logic        dec_valid_out;
    logic [6:0]  opcode_out;
    logic [2:0]  funct3_out;
    logic [6:0]  funct7_out;
    logic [4:0]  rs1_addr_out;
    logic [4:0]  rs2_addr_out;
    logic [4:0]  rd_addr_out;
    logic [11:0] csr_addr_out;
    logic [24:0] instr_out;
    logic [31:0] pc_out;
    logic        illegal_out;
    logic [1:0]  count_out;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t sb[$];
    int     n_vec;
    int     n_err;

    msrv32_decode_buffer #(
        .WIDTH(32), .ADDR_WIDTH(5), .DEPTH(DEPTH), .NOP_INSTR(NOP)
    ) dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst_n),
        .flush_in(flush_in),
        .instr_in(instr_in),
        .pc_in(pc_in),
        .instr_valid_in(instr_valid_in),
        .instr_ready_out(instr_ready_out),
        .dec_ready_in(dec_ready_in),
        .dec_valid_out(dec_valid_out),
        .opcode_out(opcode_out),
        .funct3_out(funct3_out),
        .funct7_out(funct7_out),
        .rs1_addr_out(rs1_addr_out),
        .rs2_addr_out(rs2_addr_out),
        .rd_addr_out(rd_addr_out),
        .csr_addr_out(csr_addr_out),
        .instr_out(instr_out),
        .pc_out(pc_out),
        .illegal_out(illegal_out),
        .count_out(count_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit legal_op(input logic [6:0] op);
        case (op)
            7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h0f, 7'h73: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    // Field vector in a fixed order, built from an instruction word by the bench.
    function automatic logic [70:0] fields_of(input logic [31:0] w);
        return {w[6:0], w[14:12], w[31:25], w[19:15], w[24:20], w[11:7], w[31:20], w[31:7]};
    endfunction

    function automatic logic [70:0] dut_fields();
        return {opcode_out, funct3_out, funct7_out, rs1_addr_out, rs2_addr_out,
                rd_addr_out, csr_addr_out, instr_out};
    endfunction

    // One clock: drive inputs, compare against the scoreboard, clock, retire.
    task automatic step(input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                        input logic ready, input logic flush);
        logic        exp_valid;
        logic        exp_ready;
        logic        do_pop;
        logic        do_push;
        logic [31:0] head;
        instr_valid_in = valid;
        instr_in       = instr;
        pc_in          = pc;
        dec_ready_in   = ready;
        flush_in       = flush;
        #1;
        exp_valid = (sb.size() != 0) && !flush;
        exp_ready = (sb.size() < DEPTH) || (exp_valid && ready);
        head      = exp_valid ? sb[0].instr : NOP;
        n_vec++;
        if (dec_valid_out !== exp_valid || instr_ready_out !== exp_ready ||
            count_out !== 2'(sb.size())) begin
            n_err++;
            $display("FAIL step_handshake: got v=%b r=%b cnt=%0d exp v=%b r=%b cnt=%0d",
                     dec_valid_out, instr_ready_out, count_out, exp_valid, exp_ready, sb.size());
        end
        n_vec++;
        if (dut_fields() !== fields_of(head) ||
            pc_out !== (exp_valid ? sb[0].pc : 32'h0) ||
            illegal_out !== (exp_valid && !legal_op(head[6:0]))) begin
            n_err++;
            $display("FAIL step_head: got instr=%h pc=%h ill=%b exp instr=%h pc=%h",
                     {instr_out, opcode_out}, pc_out, illegal_out, head,
                     exp_valid ? sb[0].pc : 32'h0);
        end
        do_pop  = exp_valid && ready;
        do_push = valid && exp_ready && !flush;
        @(posedge clk);
        #1;
        if (flush) sb.delete();
        else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back('{instr: instr, pc: pc});
        end
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 20 && count_out != 2'd0; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_vec++;
        if (count_out !== 2'd0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got cnt=%0d exp 0", count_out);
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if (dec_valid_out !== 1'b0 || instr_ready_out !== 1'b1 || count_out !== 2'd0 ||
            opcode_out !== 7'h13 || rd_addr_out !== 5'd0 || rs1_addr_out !== 5'd0 ||
            pc_out !== 32'h0 || illegal_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b r=%b cnt=%0d op=%h rd=%0d rs1=%0d pc=%h",
                     dec_valid_out, instr_ready_out, count_out, opcode_out, rd_addr_out,
                     rs1_addr_out, pc_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_single();
        step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
        instr_valid_in = 1'b0;
        #1;
        n_vec++;
        if (dec_valid_out !== 1'b1 || opcode_out !== 7'h13 || rd_addr_out !== 5'd1 ||
            rs1_addr_out !== 5'd0 || csr_addr_out !== 12'h005 || pc_out !== 32'h100) begin
            n_err++;
            $display("FAIL single_addi: got v=%b op=%h rd=%0d rs1=%0d csr=%h pc=%h exp 1 13 1 0 005 100",
                     dec_valid_out, opcode_out, rd_addr_out, rs1_addr_out, csr_addr_out, pc_out);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_vec++;
        if (count_out !== 2'd0) begin
            n_err++;
            $display("FAIL single_pop: got cnt=%0d exp 0", count_out);
        end
    endtask

    task automatic test_full();
        step(1'b1, 32'h00100113, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h00200193, 32'h204, 1'b0, 1'b0);
        step(1'b1, 32'h00300213, 32'h208, 1'b0, 1'b0);
        n_vec++;
        if (count_out !== 2'd2 || instr_ready_out !== 1'b0) begin
            n_err++;
            $display("FAIL full_hold: got cnt=%0d r=%b exp cnt=2 r=0", count_out, instr_ready_out);
        end
        step(1'b1, 32'h00300213, 32'h208, 1'b1, 1'b0);
        n_vec++;
        if (count_out !== 2'd2 || pc_out !== 32'h204) begin
            n_err++;
            $display("FAIL full_pop_push: got cnt=%0d pc=%h exp cnt=2 pc=204", count_out, pc_out);
        end
        drain();
    endtask

    task automatic test_flush();
        step(1'b1, 32'h00a00293, 32'h300, 1'b0, 1'b0);
        step(1'b1, 32'h00b00313, 32'h304, 1'b0, 1'b0);
        step(1'b1, 32'h00c00393, 32'h308, 1'b1, 1'b1);
        n_vec++;
        if (count_out !== 2'd0 || dec_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL flush_empty: got cnt=%0d v=%b exp 0 0", count_out, dec_valid_out);
        end
        step(1'b1, 32'h00d00413, 32'h30c, 1'b1, 1'b1);
        step(1'b1, 32'h00e00493, 32'h310, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_illegal();
        step(1'b1, 32'hffffffff, 32'h400, 1'b0, 1'b0);
        step(1'b1, 32'h00000073, 32'h404, 1'b0, 1'b0);
        dec_ready_in = 1'b1;
        #1;
        n_vec++;
        if (illegal_out !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_all_ones: got %b exp 1", illegal_out);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_vec++;
        if (illegal_out !== 1'b0 || pc_out !== 32'h404) begin
            n_err++;
            $display("FAIL illegal_ecall: got ill=%b pc=%h exp 0 404", illegal_out, pc_out);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        for (int i = 0; i < 40; i++) begin
            w = $urandom();
            if ($urandom_range(3) != 0) w[6:0] = 7'h33;
            step(1'b1, w, 32'h1000 + 32'(i * 4), 1'($urandom_range(1)), 1'($urandom_range(9) == 0));
        end
        drain();
    endtask

    task automatic test_reset_mid();
        step(1'b1, 32'h00f00513, 32'h500, 1'b0, 1'b0);
        step(1'b1, 32'h01000593, 32'h504, 1'b0, 1'b0);
        instr_valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (count_out !== 2'd0 || dec_valid_out !== 1'b0 || pc_out !== 32'h0 ||
            opcode_out !== 7'h13 || instr_ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: got cnt=%0d v=%b pc=%h op=%h r=%b exp 0 0 0 13 1",
                     count_out, dec_valid_out, pc_out, opcode_out, instr_ready_out);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        flush_in       = 1'b0;
        instr_in       = '0;
        pc_in          = '0;
        instr_valid_in = 1'b0;
        dec_ready_in   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_full();
        test_flush();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
